// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock elastic buffer with programmable almost-full/empty
// thresholds, standard or first-word-fall-through read, flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       buf_in,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       buf_out,
  output logic                    out_valid,
  output logic [$clog2(DEPTH):0]  fifo_cntr,
  output logic                    buf_empt,
  output logic                    buf_full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be below DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign buf_empt     = (fifo_cntr == '0);
  assign buf_full     = (fifo_cntr == CNT_W'(DEPTH));
  assign almost_empty = (fifo_cntr <= CNT_W'(AE_THRESH));
  assign almost_full  = (fifo_cntr >= CNT_W'(AF_THRESH));

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign rd_acc = rd_en & ~buf_empt;
  assign wr_acc = wr_en & (~buf_full | rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cntr <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cntr <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_acc && !rd_acc)      fifo_cntr <= fifo_cntr + CNT_W'(1);
      else if (rd_acc && !wr_acc) fifo_cntr <= fifo_cntr - CNT_W'(1);
      if (wr_en && !wr_acc)   overflow  <= 1'b1;
      if (rd_en && buf_empt)  underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= buf_in;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] buf_p1;
    logic              vld_p1;

    // Registered read: data and its one-cycle valid pulse land together.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        buf_p1 <= '0;
        vld_p1 <= 1'b0;
      end else if (flush) begin
        vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= rd_acc;
        if (rd_acc) buf_p1 <= mem[rd_ptr];
      end
    end

    assign buf_out   = buf_p1;
    assign out_valid = vld_p1;
  end else begin : g_fwft
    assign buf_out   = buf_empt ? '0 : mem[rd_ptr];
    assign out_valid = ~buf_empt;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO: next generation of the team's 8-bit/64-entry buffer. Configurable data width and depth, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode. Adds a synchronous flush and sticky overflow/underflow error flags. Used as the generic elastic buffer between producer/consumer stages in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 64, number of entries; power of two, >= 4
AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of FIFO contents and error flags
wr_en  in  1  write request
buf_in  in  DATA_W  write data
rd_en  in  1  read request (FWFT: pop/acknowledge of head word)
buf_out  out  DATA_W  read data
out_valid  out  1  buf_out holds valid data (meaning per mode, below)
fifo_cntr  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
buf_empt  out  1  fifo_cntr == 0
buf_full  out  1  fifo_cntr == DEPTH
almost_empty  out  1  fifo_cntr <= AE_THRESH
almost_full  out  1  fifo_cntr >= AF_THRESH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, rst=1): pointers, fifo_cntr, buf_out, out_valid, overflow, underflow = 0; buf_empt=1, almost_empty=1, buf_full=0, almost_full=0 (AF_THRESH>0). Memory array not reset.
- Status flags are pure decodes of registered fifo_cntr. They change the cycle after the accepting edge.
- rd_acc = rd_en & !buf_empt.
- wr_acc = wr_en & (!buf_full | rd_acc). A write while full is accepted if a read is accepted in the same cycle.
- fifo_cntr: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- wr_ptr, rd_ptr: $clog2(DEPTH) bits, +1 on respective accept, wrap DEPTH-1 -> 0 naturally.
- Write: mem[wr_ptr] <= buf_in on wr_acc.
- Simultaneous read/write when empty: write accepted, read rejected (underflow set). New word readable from the next cycle.
- Standard mode (FWFT=0):
  - On rd_acc, buf_out <= mem[rd_ptr] at that edge; latency 1 cycle.
  - out_valid is a 1-cycle pulse in the following cycle.
  - buf_out holds its last value otherwise.
- FWFT mode (FWFT=1):
  - buf_out = mem[rd_ptr] whenever !buf_empt; out_valid = !buf_empt.
  - First word written appears on buf_out the cycle after the write edge.
  - rd_en with out_valid=1 consumes the head; the next word (if any) is presented the following cycle.
  - buf_out is don't-care when out_valid=0.
- overflow <= 1 when wr_en & !wr_acc. underflow <= 1 when rd_en & buf_empt. Both hold until flush or rst.
- flush (sync, highest priority after rst):
  - Clears pointers, fifo_cntr, out_valid, overflow, underflow.
  - wr_en/rd_en in the same cycle are ignored and set no error flags.
  - Memory contents untouched; buf_out holds.
- Reset mid-operation: immediate return to reset state regardless of clk; data in flight lost.
- Elaboration errors: DEPTH not a power of two, AF_THRESH > DEPTH, or AE_THRESH >= DEPTH.

Test Plan:
- Reset, then write 0x01..0x40 (DEPTH=64) with no reads -> fifo_cntr=64, buf_full=1, almost_full=1 from 60 onward, overflow=0; one extra write of 0xAA -> overflow=1, fifo_cntr=64.
- Read all 64 entries, standard mode -> buf_out 0x01..0x40 in order, each one cycle after rd_en, out_valid pulses; 65th read -> underflow=1, fifo_cntr=0, buf_out holds 0x40.
- Full FIFO, wr_en=rd_en=1 for 10 cycles -> fifo_cntr stays 64, no overflow, read order preserved across pointer wrap.
- FWFT=1: write 0x5A into empty FIFO -> next cycle buf_out=0x5A, out_valid=1 with no rd_en; rd_en one cycle -> out_valid=0, buf_empt=1.
- Fill 20 words, set overflow/underflow, assert flush together with wr_en=1 -> fifo_cntr=0, buf_empt=1, both error flags 0, the write is dropped.
- Assert rst asynchronously mid-burst (between clock edges) -> all outputs return to reset values immediately; first post-reset write and read return the new data.
